// File: rtl/prbs31_checker_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1) used by the checker and the matching generator.
package prbs_pkg;

  localparam int PRBS_LEN   = 31;
  localparam int PRBS_TAP_A = 27;
  localparam int PRBS_TAP_B = 30;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // sr[0] holds the most recent bit; the next bit is the XOR of the two taps.
  function automatic logic prbs_next_bit(input logic [PRBS_LEN-1:0] sr);
    return sr[PRBS_TAP_A] ^ sr[PRBS_TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Stream and status bundle for the PRBS31 checker: the master drives bits, the checker reports lock and errors.
interface prbs31_checker_if #(
  parameter int ERR_CNT_W = 16
);

  logic                 bit_valid;
  logic                 bit_in;
  logic                 clr_cnt;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output bit_valid, bit_in, clr_cnt,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  bit_valid, bit_in, clr_cnt,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/prbs31_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a simultaneous increment.
module prbs_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 serial checker: fills, verifies and locks onto the stream, then counts bit errors while locked.
// Define PRBS_CHK_LOSS_EN to build the loss-of-lock monitor; without it LOCKED is sticky until reset.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int SYNC_CNT    = 64,
  parameter int ERR_CNT_W   = 16,
  parameter int LOSS_WIN    = 256,
  parameter int LOSS_THRESH = 8
) (
  input logic             clk,
  input logic             rst_n,
  prbs31_checker_if.slave bus
);

  localparam logic [4:0]  FILL_LAST = 5'(PRBS_LEN - 1);
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_CNT - 1);

  if (SYNC_CNT < 2 || SYNC_CNT > 65535 || ERR_CNT_W < 2 || LOSS_WIN < 32 ||
      (LOSS_WIN & (LOSS_WIN - 1)) != 0 || LOSS_THRESH < 1 || LOSS_THRESH > LOSS_WIN) begin : g_bad_cfg
    $error("prbs31_checker: illegal parameter set");
  end

  chk_state_e          state_q, state_d;
  logic [PRBS_LEN-1:0] sr_q, sr_d;
  logic [4:0]          fill_q, fill_d;
  logic [15:0]         good_q, good_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                exp_bit, bit_match, lock_hit, err_hit, loss_hit;

  // An all-zero history can never be a valid PRBS31 state, so it never counts as a match.
  assign exp_bit   = prbs_next_bit(sr_q);
  assign bit_match = (bus.bit_in == exp_bit) && (sr_q != '0);
  assign lock_hit  = bus.bit_valid && (state_q == VERIFY) && bit_match && (good_q == SYNC_LAST);
  assign err_hit   = bus.bit_valid && (state_q == LOCKED) && (bus.bit_in != exp_bit);

`ifdef PRBS_CHK_LOSS_EN
  localparam int                WIN_W     = $clog2(LOSS_WIN);
  localparam int                WERR_W    = $clog2(LOSS_THRESH + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THRESH - 1);

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0] win_err_q, win_err_d;

  // Windows restart on lock entry, on loss, and after their last bit (whose error still counts).
  always_comb begin
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    loss_hit  = err_hit && (win_err_q == WERR_LAST);
    if (lock_hit || loss_hit ||
        (bus.bit_valid && (state_q == LOCKED) && (win_cnt_q == WIN_LAST))) begin
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (bus.bit_valid && (state_q == LOCKED)) begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
      win_err_d = win_err_q + WERR_W'(err_hit);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end
`else
  assign loss_hit = 1'b0;
`endif

  // Once locked, the local generator free-runs on its own prediction so one flipped bit counts once.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    good_d  = good_q;
    if (bus.bit_valid) begin
      unique case (state_q)
        HUNT: begin
          sr_d   = {sr_q[PRBS_LEN-2:0], bus.bit_in};
          fill_d = fill_q + 5'd1;
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          sr_d   = {sr_q[PRBS_LEN-2:0], bus.bit_in};
          good_d = bit_match ? (good_q + 16'd1) : '0;
          if (lock_hit) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          sr_d = {sr_q[PRBS_LEN-2:0], exp_bit};
          if (loss_hit) begin
            fill_d  = '0;
            good_d  = '0;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d    = (state_d == LOCKED);
    err_pulse_d = err_hit;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  prbs_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_hit),
    .clr   (bus.clr_cnt),
    .count (bus.err_count)
  );

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Randomised scoreboard bench for prbs31_checker against a recurrence-level reference model.
// Loss-of-lock expectations follow PRBS_CHK_LOSS_EN the same way the design does.
module tb_prbs31_checker;

  localparam int SYNC_CNT    = 64;
  localparam int ERR_CNT_W   = 4;
  localparam int LOSS_WIN    = 256;
  localparam int LOSS_THRESH = 8;
  localparam int CNT_MAX     = (1 << ERR_CNT_W) - 1;
  localparam int LOCK_BITS   = 31 + SYNC_CNT;
  localparam int M_HUNT      = 0;
  localparam int M_VERIFY    = 1;
  localparam int M_LOCKED    = 2;

  typedef struct {
    bit locked;
    bit pulse;
    int cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  prbs31_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  prbs31_checker #(
    .SYNC_CNT    (SYNC_CNT),
    .ERR_CNT_W   (ERR_CNT_W),
    .LOSS_WIN    (LOSS_WIN),
    .LOSS_THRESH (LOSS_THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  bit    hist[$];
  int    m_mode, m_fill, m_good, m_win, m_werr, m_cnt;
  bit    m_pulse;
  logic [30:0] gen;
  int    n_valid, lock_at, pulse_cnt;
  bit    seen_lock, ever_locked;

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, wanted %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    repeat (31) hist.push_back(1'b0);
    m_mode  = M_HUNT;
    m_fill  = 0;
    m_good  = 0;
    m_win   = 0;
    m_werr  = 0;
    m_cnt   = 0;
    m_pulse = 1'b0;
  endfunction

  // Reference: each new PRBS31 bit equals the bits 28 and 31 positions back, XORed.
  function automatic void model_step(input bit v, input bit b, input bit clr);
    bit pred, err, quiet;
    m_pulse = 1'b0;
    if (v) begin
      pred  = hist[hist.size()-28] ^ hist[hist.size()-31];
      quiet = 1'b1;
      foreach (hist[i]) if (hist[i]) quiet = 1'b0;
      case (m_mode)
        M_HUNT: begin
          hist.push_back(b);
          m_fill++;
          if (m_fill == 31) begin
            m_mode = M_VERIFY;
            m_fill = 0;
            m_good = 0;
          end
        end
        M_VERIFY: begin
          hist.push_back(b);
          if (!quiet && b == pred) begin
            m_good++;
            if (m_good == SYNC_CNT) begin
              m_mode = M_LOCKED;
              m_win  = 0;
              m_werr = 0;
            end
          end else begin
            m_good = 0;
          end
        end
        default: begin
          err = (b != pred);
          hist.push_back(pred);
          if (err) begin
            m_pulse = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
`ifdef PRBS_CHK_LOSS_EN
          m_win++;
          if (err) m_werr++;
          if (m_werr == LOSS_THRESH) begin
            m_mode = M_HUNT;
            m_fill = 0;
            m_good = 0;
            m_win  = 0;
            m_werr = 0;
          end else if (m_win == LOSS_WIN) begin
            m_win  = 0;
            m_werr = 0;
          end
`endif
        end
      endcase
      void'(hist.pop_front());
    end
    if (clr) m_cnt = 0;
  endfunction

  function automatic bit gen_bit();
    bit nb;
    nb  = gen[27] ^ gen[30];
    gen = {gen[29:0], nb};
    return nb;
  endfunction

  task automatic apply_stimulus(input bit v, input bit b, input bit clr);
    exp_t e;
    @(negedge clk);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.clr_cnt   = clr;
    model_step(v, b, clr);
    e.locked = (m_mode == M_LOCKED);
    e.pulse  = m_pulse;
    e.cnt    = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    if (v) n_valid++;
    if (bus.locked) begin
      ever_locked = 1'b1;
      if (!seen_lock) begin
        seen_lock = 1'b1;
        lock_at   = n_valid;
      end
    end
    if (bus.err_pulse) pulse_cnt++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clr_cnt   = 1'b0;
    model_reset();
    #1;
    check_output("reset_locked", bus.locked, 0);
    check_output("reset_err_pulse", bus.err_pulse, 0);
    check_output("reset_err_count", bus.err_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic run_clean(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, gen_bit(), 1'b0);
  endtask

  task automatic run_until_lock(input int budget, input bit rand_valid, input string name);
    bit v, b;
    n_valid   = 0;
    seen_lock = 1'b0;
    lock_at   = 0;
    for (int i = 0; i < budget && !seen_lock; i++) begin
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      b = v ? gen_bit() : 1'($urandom_range(0, 1));
      apply_stimulus(v, b, 1'b0);
    end
    check_output(name, lock_at, LOCK_BITS);
  endtask

  // Monitor: every cycle with a pending expectation is compared one step after the sampling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_locked", bus.locked, e.locked);
        check_output("sb_err_pulse", bus.err_pulse, e.pulse);
        check_output("sb_err_count", bus.err_count, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clr_cnt   = 1'b0;

    $display("[TB] clean stream from reset");
    apply_reset();
    gen = 31'd1;
    run_until_lock(300, 1'b0, "first_lock_latency");
    run_clean(10000 - LOCK_BITS);
    check_output("clean_err_count", bus.err_count, 0);
    check_output("clean_locked", bus.locked, 1);

    $display("[TB] single inverted bit");
    pulse_cnt = 0;
    apply_stimulus(1'b1, !gen_bit(), 1'b0);
    run_clean(100);
    check_output("single_pulses", pulse_cnt, 1);
    check_output("single_err_count", bus.err_count, 1);
    check_output("single_locked", bus.locked, 1);

    $display("[TB] saturation and clear priority");
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b1, !gen_bit(), 1'b0);
      run_clean(63);
    end
    check_output("sat_err_count", bus.err_count, CNT_MAX);
    apply_stimulus(1'b1, !gen_bit(), 1'b1);
    check_output("clr_err_count", bus.err_count, 0);
    check_output("clr_err_pulse", bus.err_pulse, 1);
    run_clean(300);
    while (m_win > LOSS_WIN - 16) apply_stimulus(1'b1, gen_bit(), 1'b0);

    $display("[TB] inverted stream while locked");
    pulse_cnt = 0;
    repeat (LOSS_THRESH) apply_stimulus(1'b1, !gen_bit(), 1'b0);
    check_output("burst_err_count", bus.err_count, LOSS_THRESH);
    check_output("burst_pulses", pulse_cnt, LOSS_THRESH);
`ifdef PRBS_CHK_LOSS_EN
    check_output("loss_unlocked", bus.locked, 0);
    run_until_lock(300, 1'b0, "relock_latency");
    check_output("relock_err_count", bus.err_count, LOSS_THRESH);
`else
    check_output("sticky_locked", bus.locked, 1);
    run_clean(LOCK_BITS);
    check_output("sticky_still_locked", bus.locked, 1);
    check_output("sticky_err_count", bus.err_count, LOSS_THRESH);
`endif

    $display("[TB] stuck-low input after mid-run reset");
    apply_reset();
    ever_locked = 1'b0;
    repeat (2000) apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("zero_no_lock", ever_locked, 0);
    gen = 31'd1;
    run_until_lock(300, 1'b0, "post_zero_lock_latency");

    $display("[TB] random bit_valid");
    apply_reset();
    gen = 31'd1;
    run_until_lock(800, 1'b1, "random_valid_lock_latency");
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) apply_stimulus(1'b1, gen_bit(), 1'b0);
      else apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check_output("random_valid_err_count", bus.err_count, 0);

    repeat (2) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 checker that consumes the one-bit-per-cycle pseudo-random stream produced by our PRBS31 generator, for loop-back testing of the chip's I/O path. It self-synchronises to the incoming stream (polynomial x^31 + x^28 + 1), declares lock, then counts bit errors. A loss-of-lock monitor returns it to hunting after sustained errors. Sits directly downstream of the generator, typically fed from a dedicated input pin.

## Interface
- SYNC_CNT, 64: consecutive correct bits required in VERIFY before declaring lock (2..65535).
- ERR_CNT_W, 16: width of the saturating error counter (>=2).
- LOSS_WIN, 256: loss-monitor window length in valid bits (power of two, >=32).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..LOSS_WIN).
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-high; clock clk.
- bit_valid  input  1  qualifies bit_in this cycle.
- bit_in  input  1  received stream bit.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per detected error while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of errors detected while LOCKED.

## Operation
- sr[30:0]: shift register, sr[0] = most recent bit. Prediction: exp = sr[27] ^ sr[30]. Every update is sr <= {sr[29:0], b}.
- No state, register or output changes when bit_valid = 0.
- HUNT: b = bit_in. A fill counter counts 31 valid bits, then the block enters VERIFY with good_cnt = 0.
- VERIFY: b = bit_in (self-synchronising). A match (bit_in == exp and sr != 0) increments good_cnt. When good_cnt reaches SYNC_CNT, the block enters LOCKED. A mismatch clears good_cnt and the block stays in VERIFY.
- All-zero guard: sr == 0 counts as a mismatch, so a stuck-low input never locks.
- LOCKED: b = exp, so the local generator free-runs and a single flipped bit is counted once. A mismatch pulses err_pulse and increments err_count, which saturates at all-ones.
- Loss monitor (LOCKED only): win_cnt counts valid bits and win_err counts errors.
  - If win_err reaches LOSS_THRESH, the block goes to HUNT, clears the fill counter and clears good_cnt.
  - win_cnt and win_err clear after the LOSS_WIN-th bit of a window. An error on that last bit counts toward the closing window.
  - Both counters clear on entry to LOCKED.
- clr_cnt wins over a simultaneous increment: err_count becomes 0, but err_pulse still fires.
- err_count keeps its value across loss and relock. Only clr_cnt or reset clears it.

## Timing
- Reset values: state HUNT, sr = 0, all counters 0, locked = 0, err_pulse = 0, err_count = 0.
- Reset mid-operation aborts immediately; nothing is retained.
- All outputs are registered.
- locked rises one cycle after the clock edge that samples the SYNC_CNT-th consecutive good bit. With a clean stream and continuous valid, that is 31 + SYNC_CNT valid bits after reset.
- err_pulse and the err_count increment appear one cycle after the erroneous bit is sampled.
- locked falls one cycle after the bit that makes win_err reach LOSS_THRESH. That bit itself still produces err_pulse.

## Configuration
- PRBS_CHK_LOSS_EN defined: the loss monitor above is built and LOCKED exits on sustained errors.
- PRBS_CHK_LOSS_EN undefined: win_cnt and win_err are not built and LOCKED is sticky until reset. LOSS_WIN and LOSS_THRESH are then ignored.

## Structure
- Package prbs_pkg holds:
  - PRBS31 constants: length 31 and taps 27/30, shared with the generator.
  - The state enum HUNT/VERIFY/LOCKED.
- One sub-module, prbs_sat_counter: parameterised width, with inc, clr (clr priority) and saturation. Used for err_count.

## Test plan
- Reset, then a generator stream (seed 1) with continuous valid -> locked rises 95 cycles after the first valid bit (SYNC_CNT = 64); err_count stays 0 over 10,000 bits.
- While locked, invert one bit -> exactly one err_pulse, err_count = 1, locked stays 1.
- Constant 0 input for 2,000 bits -> locked never asserts; then a clean stream -> lock after 95 bits.
- LOSS_THRESH = 8, LOSS_WIN = 256: invert the stream while locked -> locked falls after the 8th error with err_count = 8. Restore the stream -> relock 95 bits later with err_count still 8.
- ERR_CNT_W = 4: 20 single-bit errors spaced 64 bits apart -> err_count = 15. clr_cnt on the same cycle as an error -> err_count = 0 and err_pulse = 1.
- bit_valid randomly 50% -> lock occurs at the 95th valid bit, with no change on invalid cycles.
